msg_fifo_arbiter: RTL and testbench
===================================

MSG_FIFO_ARBITER -- requirements
Module: msg_fifo_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 3, number of message producers; FIFO_DEPTH, default 256, capacity of the downstream message FIFO in words; USEDW_W, default 8, width of the FIFO fill-level input.
REQ-002 SHALL have ports: clk  in  1  the single clock; all logic is clocked on the rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req  in  NUM_REQ  per-producer message request; the producer holds it high until its done pulse.
REQ-005 SHALL have ports: req_len  in  2*NUM_REQ  per-producer message length minus 1, giving 1-4 words; held stable while req is high.
REQ-006 SHALL have ports: req_data  in  32*NUM_REQ  per-producer current word; the producer advances it on the cycle after its pop.
REQ-007 SHALL have ports: grant  out  NUM_REQ  one-hot, high for the whole burst of the selected producer.
REQ-008 SHALL have ports: pop  out  NUM_REQ  one pulse per word consumed from that producer.
REQ-009 SHALL have ports: done  out  NUM_REQ  single-cycle pulse on the final word of a burst.
REQ-010 SHALL have ports: abort  out  NUM_REQ  single-cycle pulse when a burst is killed by flush.
REQ-011 SHALL have ports: fifo_data  out  32  word written to the FIFO.
REQ-012 SHALL have ports: fifo_wrreq  out  1  FIFO write enable.
REQ-013 SHALL have ports: fifo_usedw  in  USEDW_W  current FIFO fill level.
REQ-014 SHALL have ports: flush  in  1  synchronous flush, the same strobe that clears the FIFO.
REQ-015 SHALL have ports: busy  out  1  high while in the BURST state.
REQ-016 SHALL have ports: stall_count  out  16  saturating count of cycles blocked by lack of FIFO space.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and BURST.
REQ-018 In IDLE, SHALL search req round-robin starting at pointer rr (range 0..NUM_REQ-1) and take the first requester found as the winner.
REQ-019 SHALL admit the winner only when fifo_usedw + req_len[w] + 1 <= FIFO_DEPTH-1; the sum is computed in USEDW_W+2 bits so it cannot overflow.
REQ-020 On admission, SHALL latch the winner index and word count, set grant[w] on the next edge, and move to BURST.
REQ-021 If the winner does not fit, SHALL stay in IDLE, leave rr unchanged, and increment stall_count, saturating at 16'hFFFF. A lower-priority short message SHALL NOT bypass the blocked winner; this preserves fairness.
REQ-022 In BURST, fifo_wrreq SHALL be 1 every cycle, fifo_data SHALL equal req_data[w], and pop[w] SHALL be 1. These outputs are combinational from the registered state and index.
REQ-023 On the last word of a burst, SHALL pulse done[w], set rr to (w+1) mod NUM_REQ, clear grant, and return to IDLE.
REQ-024 Latency: req sampled high in IDLE at edge N gives its first FIFO write in cycle N+1; an L-word message occupies L cycles.
REQ-025 SHALL always insert one IDLE cycle between bursts, so fifo_usedw has settled before the next admission check.
REQ-026 Deassertion of req during a burst SHALL be ignored; the burst always completes its latched length.
REQ-027 flush during BURST SHALL suppress fifo_wrreq and pop that cycle, pulse abort[w], clear grant, return to IDLE, and leave rr at w+1.
REQ-028 flush in IDLE SHALL block any admission that cycle.
REQ-029 When NUM_REQ is not a power of 2, SHALL never select or point rr at a nonexistent requester.
REQ-030 Outside BURST, fifo_wrreq, pop, done and abort SHALL be 0, and fifo_data SHALL be 0.

Reset
REQ-031 reset_n low SHALL asynchronously force state to IDLE, rr to 0, grant to 0, latched index and count to 0, and stall_count to 0; all outputs then read 0.
REQ-032 Reset asserted mid-burst SHALL drop the burst with no done or abort pulse; after release, the first admission check occurs on the first edge with reset_n high.

Verification
REQ-033 Single message: req=3'b001, req_len[1:0]=2, usedw=0, data sequence A,B,C -> grant[0] high for 3 cycles; FIFO receives A,B,C on consecutive cycles starting 1 cycle after req; done[0] on C.
REQ-034 Round-robin: all three requesters request 1-word messages continuously -> grant order 0,1,2,0,...; exactly one IDLE cycle between bursts.
REQ-035 Space limit: usedw=252, req_len=3 (4 words) -> no grant and stall_count increments each cycle; dropping usedw to 251 -> grant on the next edge.
REQ-036 Flush on the 2nd word of a 4-word burst -> exactly 1 FIFO write; abort pulse and no done; IDLE next cycle; next grant goes to requester w+1.
REQ-037 Async reset: reset_n low mid-burst, between clock edges -> grant and fifo_wrreq go 0 immediately; stall_count=0; after release, requester 0 is served first.
REQ-038 Saturation: a blocked request held for 70000 cycles -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/msg_fifo_arbiter.sv
// Round-robin arbiter that moves 1-4 word messages from NUM_REQ producers into one FIFO.
// A burst is admitted only if the whole message fits; one IDLE cycle always separates bursts.
module msg_fifo_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [2*NUM_REQ-1:0]    req_len,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      pop,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      abort,
  output logic [31:0]             fifo_data,
  output logic                    fifo_wrreq,
  input  logic [USEDW_W-1:0]      fifo_usedw,
  input  logic                    flush,
  output logic                    busy,
  output logic [15:0]             stall_count
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = USEDW_W + 2;
  localparam logic [SUM_W-1:0] LIMIT    = SUM_W'(FIFO_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d, idx_q, idx_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [15:0]        stall_q, stall_d;

  logic               win_found, win_fits;
  logic [IDX_W-1:0]   win_idx, idx_next;
  logic [IDX_W:0]     cand;
  logic [1:0]         win_len;
  logic [SUM_W-1:0]   need;

  // Candidate index wraps explicitly so a non-power-of-2 NUM_REQ never names a missing producer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= NUM_EXT) cand = cand - NUM_EXT;
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_len  = req_len[{win_idx, 1'b0} +: 2];
  assign need     = SUM_W'(fifo_usedw) + SUM_W'(win_len) + SUM_W'(1);
  assign win_fits = (need <= LIMIT);
  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    stall_d    = stall_q;
    fifo_wrreq = 1'b0;
    fifo_data  = '0;
    pop        = '0;
    done       = '0;
    abort      = '0;
    case (state_q)
      IDLE: begin
        // The blocked winner holds the slot: no lower-priority message may bypass it.
        if (!flush && win_found) begin
          if (win_fits) begin
            state_d          = BURST;
            idx_d            = win_idx;
            cnt_d            = win_len;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
          end else if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      BURST: begin
        fifo_data = req_data[{idx_q, 5'b0} +: 32];
        if (flush) begin
          abort[idx_q] = 1'b1;
          state_d      = IDLE;
          grant_d      = '0;
          rr_d         = idx_next;
        end else begin
          fifo_wrreq = 1'b1;
          pop[idx_q] = 1'b1;
          if (cnt_q == 2'd0) begin
            done[idx_q] = 1'b1;
            state_d     = IDLE;
            grant_d     = '0;
            rr_d        = idx_next;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      stall_q <= stall_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == BURST);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_msg_fifo_arbiter.sv
// Bench for msg_fifo_arbiter: producer models, a cycle-level reference of the arbitration rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_msg_fifo_arbiter;
  localparam int N     = 3;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_len;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    grant, pop, done, abort;
  logic [31:0]     fifo_data;
  logic            fifo_wrreq;
  logic [7:0]      fifo_usedw;
  logic            flush;
  logic            busy;
  logic [15:0]     stall_count;

  msg_fifo_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH), .USEDW_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_len(req_len), .req_data(req_data),
    .grant(grant), .pop(pop), .done(done), .abort(abort), .fifo_data(fifo_data),
    .fifo_wrreq(fifo_wrreq), .fifo_usedw(fifo_usedw), .flush(flush), .busy(busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Producer state: each word is tagged A / producer / message number / word number.
  int   p_word [N];
  int   p_msg  [N];
  int   p_len  [N];
  logic p_req  [N];
  int   mode;
  int   fix_len;

  // Reference model state.
  int m_owner = -1;
  int m_left  = 0;
  int m_sent  = 0;
  int m_ptr   = 0;
  int m_stall = 0;

  logic [N-1:0] obs_pop, obs_done, obs_abort, prev_grant;
  int           w_t[$];
  logic [31:0]  w_dat[$];
  int           g_who[$];
  int           g_t[$];
  int           cyc = 0;
  int           done_cnt, busy_cnt, last_done_t, t_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]              = p_req[i];
      req_len[2*i +: 2]   = 2'(p_len[i]);
      req_data[32*i +: 32] = {4'hA, 4'(i), 8'(p_msg[i]), 16'(p_word[i])};
    end
  endtask

  task automatic start_msg(input int i, input int len);
    p_msg[i]++;
    p_word[i] = 0;
    p_len[i]  = len;
    p_req[i]  = 1'b1;
    drive();
  endtask

  // Advance one clock; producers react to what the compare process observed last cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (obs_pop[i]) p_word[i]++;
      if (obs_done[i] || obs_abort[i]) begin
        p_word[i] = 0;
        if (mode == 1) begin
          p_msg[i]++;
          p_len[i] = fix_len;
          p_req[i] = 1'b1;
        end else begin
          p_req[i] = 1'b0;
        end
      end else if (mode == 2 && !p_req[i] && $urandom_range(0, 3) == 0) begin
        p_msg[i]++;
        p_word[i] = 0;
        p_len[i]  = $urandom_range(0, 3);
        p_req[i]  = 1'b1;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush   = 1'b0;
    mode    = 0;
    for (int i = 0; i < N; i++) begin
      p_req[i]  = 1'b0;
      p_word[i] = 0;
    end
    drive();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Compare process: checks every cycle against the model, then advances the model.
  always @(negedge clk) begin : compare
    logic [N-1:0] e_hot;
    logic         e_wr;
    int           w, len, who;
    cyc++;
    if (!reset_n) begin
      chk("reset_outputs", {grant, pop, done, abort, fifo_wrreq, busy, fifo_data, stall_count}, 64'd0);
      m_owner = -1; m_ptr = 0; m_stall = 0;
      obs_pop = '0; obs_done = '0; obs_abort = '0; prev_grant = '0;
    end else begin
      e_hot = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_wr  = (m_owner >= 0) && !flush;
      chk("busy", busy, m_owner >= 0);
      chk("grant", grant, e_hot);
      chk("fifo_wrreq", fifo_wrreq, e_wr);
      chk("pop", pop, e_wr ? e_hot : '0);
      chk("done", done, (e_wr && m_left == 1) ? e_hot : '0);
      chk("abort", abort, (m_owner >= 0 && flush) ? e_hot : '0);
      chk("stall_count", stall_count, m_stall);
      if (e_wr) chk("fifo_data", fifo_data, {4'hA, 4'(m_owner), 8'(p_msg[m_owner]), 16'(m_sent)});
      else if (m_owner < 0) chk("fifo_data_idle", fifo_data, 0);

      obs_pop = pop; obs_done = done; obs_abort = abort;
      if (fifo_wrreq) begin w_t.push_back(cyc); w_dat.push_back(fifo_data); end
      if (done != '0) begin done_cnt++; last_done_t = cyc; end
      if (busy) busy_cnt++;
      if (grant != '0 && prev_grant == '0) begin
        who = -1;
        for (int k = 0; k < N; k++) if (grant[k]) who = k;
        g_who.push_back(who);
        g_t.push_back(cyc);
      end
      prev_grant = grant;

      if (m_owner >= 0) begin
        if (flush) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else begin
          m_sent++; m_left--;
          if (m_left == 0) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
        end
      end else if (!flush) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          len = int'(req_len[2*w +: 2]) + 1;
          if (int'(fifo_usedw) + len <= DEPTH - 1) begin
            m_owner = w; m_left = len; m_sent = 0;
          end else if (m_stall < 65535) begin
            m_stall++;
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; fifo_usedw = '0; mode = 0; fix_len = 0;
    for (int i = 0; i < N; i++) begin p_req[i] = 1'b0; p_len[i] = 0; p_word[i] = 0; p_msg[i] = 0; end
    drive();
    repeat (3) tick();
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall_count, 0);
    reset_n = 1'b1;

    // Single 3-word message from producer 0.
    w_t.delete(); w_dat.delete(); done_cnt = 0; busy_cnt = 0;
    start_msg(0, 2);
    t_req = cyc + 1;
    repeat (6) tick();
    chk("single_nwords", w_dat.size(), 3);
    if (w_dat.size() == 3) begin
      chk("single_word_a", w_dat[0], 32'hA001_0000);
      chk("single_word_b", w_dat[1], 32'hA001_0001);
      chk("single_word_c", w_dat[2], 32'hA001_0002);
      chk("single_first_t", w_t[0], t_req + 1);
      chk("single_last_t", w_t[2], t_req + 3);
    end
    chk("single_done_t", last_done_t, t_req + 3);
    chk("single_grant_cycles", busy_cnt, 3);
    chk("single_done_cnt", done_cnt, 1);

    // Async reset mid-burst; pointer is 1 so producer 1 wins first.
    start_msg(0, 0);
    start_msg(1, 3);
    tick();
    chk("rr_after_single", grant, 3'b010);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_wrreq", fifo_wrreq, 0);
    chk("async_stall", stall_count, 0);
    for (int i = 0; i < N; i++) p_word[i] = 0;
    drive();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("after_reset_first", grant, 3'b001);
    repeat (12) tick();

    // Round robin with continuous 1-word messages.
    do_reset();
    mode = 1; fix_len = 0;
    g_who.delete(); g_t.delete();
    for (int i = 0; i < N; i++) start_msg(i, 0);
    repeat (20) tick();
    chk("rr_count", g_who.size() >= 6, 1);
    if (g_who.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", g_who[k], k % 3);
      chk("rr_gap_a", g_t[1] - g_t[0], 2);
      chk("rr_gap_b", g_t[5] - g_t[4], 2);
    end
    mode = 0;
    repeat (8) tick();

    // Space limit: blocked 4-word winner, short message behind it must not bypass.
    do_reset();
    fifo_usedw = 8'd252;
    start_msg(0, 3);
    start_msg(1, 0);
    repeat (5) tick();
    chk("space_stall", stall_count, 5);
    chk("space_no_grant", grant, 0);
    fifo_usedw = 8'd251;
    tick();
    chk("space_grant", grant, 3'b001);
    repeat (12) tick();

    // Flush on the second word of a 4-word burst.
    do_reset();
    fifo_usedw = '0;
    start_msg(0, 3);
    w_dat.delete(); w_t.delete(); done_cnt = 0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("flush_abort", abort, 3'b001);
    chk("flush_wrreq", fifo_wrreq, 0);
    tick();
    flush = 1'b0;
    chk("flush_idle", busy, 0);
    chk("flush_nwords", w_dat.size(), 1);
    chk("flush_no_done", done_cnt, 0);
    start_msg(1, 0);
    start_msg(2, 0);
    tick();
    chk("flush_next_grant", grant, 3'b010);
    repeat (8) tick();

    // Randomized traffic with occasional flush and a FIFO often near full.
    do_reset();
    mode = 2;
    for (int c = 0; c < 3000; c++) begin
      fifo_usedw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 250));
      flush      = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0; fifo_usedw = '0; mode = 0;
    repeat (20) tick();

    // Saturation of the stall counter.
    do_reset();
    fifo_usedw = 8'd255;
    start_msg(0, 0);
    repeat (70000) tick();
    chk("sat_stall", stall_count, 16'hFFFF);
    chk("sat_no_grant", grant, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
